// File: rtl/pixel_plot_sink_if.sv
// Pixel plot request channel: a game datapath drives x/y/colour/plot and the
// sink answers with ready.
interface pixel_plot_sink_if #(
  parameter int COLOUR_BITS = 3
);
  logic                   plot;
  logic [7:0]             x;
  logic [6:0]             y;
  logic [COLOUR_BITS-1:0] colour;
  logic                   ready;

  modport master (output plot, x, y, colour, input ready);
  modport slave  (input plot, x, y, colour, output ready);
endinterface

// File: rtl/pixel_plot_sink.sv
// Pixel plot sink: buffers bounds-checked plot requests, writes them to a framebuffer
// port and runs full-screen clear sweeps. Define PLOT_DROP_COUNT_EN to count dropped requests.
module pixel_plot_sink #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int COLOUR_BITS = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  pixel_plot_sink_if.slave       pix,
  input  logic                   clear,
  input  logic [COLOUR_BITS-1:0] clear_colour,
  output logic                   busy,
  output logic [14:0]            mem_addr,
  output logic [COLOUR_BITS-1:0] mem_data,
  output logic                   mem_we,
  output logic [7:0]             dropped_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state;
  logic [14:0]            fifo_addr [FIFO_DEPTH];
  logic [COLOUR_BITS-1:0] fifo_col  [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   clear_pending;
  logic [COLOUR_BITS-1:0] fill_colour;
  logic [14:0]            sweep;

  logic        fifo_full, fifo_empty, ready_int, accept, in_range, push, pop;
  logic [14:0] enq_addr;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign ready_int  = !fifo_full && !clear_pending && (state != CLEAR);
  assign pix.ready  = ready_int;
  assign accept     = pix.plot && ready_int;
  assign in_range   = (32'(pix.x) < WIDTH) && (32'(pix.y) < HEIGHT);
  assign push       = accept && in_range;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign enq_addr   = 15'(pix.y) * 15'(WIDTH) + 15'(pix.x);
  assign busy       = !fifo_empty || clear_pending || (state == CLEAR);

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= enq_addr;
      fifo_col[wr_ptr]  <= pix.colour;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      clear_pending <= 1'b0;
      fill_colour   <= '0;
      sweep         <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
    end else begin
      mem_we <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A clear arriving while one is pending or running is dropped.
      if (clear && !clear_pending && state != CLEAR) begin
        clear_pending <= 1'b1;
        fill_colour   <= clear_colour;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            mem_we   <= 1'b1;
            mem_addr <= fifo_addr[rd_ptr];
            mem_data <= fifo_col[rd_ptr];
            rd_ptr   <= rd_ptr + PW'(1);
          end else if (clear_pending) begin
            state <= CLEAR;
            sweep <= '0;
          end
        end
        CLEAR: begin
          mem_we   <= 1'b1;
          mem_addr <= sweep;
          mem_data <= fill_colour;
          if (sweep == LAST_ADDR) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
          end else begin
            sweep <= sweep + 15'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLOT_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) dropped_count <= '0;
    else if (accept && !in_range && dropped_count != 8'hFF)
      dropped_count <= dropped_count + 8'd1;
  end
`else
  assign dropped_count = '0;
`endif
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: plot latency, ordering, bounds drops,
// clear sweep with ignored second clear, and reset mid-sweep.
module tb_pixel_plot_sink;
  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [2:0] clear_colour;
  logic       busy;
  logic [14:0] mem_addr;
  logic [2:0] mem_data;
  logic       mem_we;
  logic [7:0] dropped_count;
  int checks = 0;
  int errors = 0;

  pixel_plot_sink_if #(.COLOUR_BITS(3)) pix ();

  pixel_plot_sink dut (
    .clk(clk), .reset(reset), .pix(pix), .clear(clear), .clear_colour(clear_colour),
    .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_plot(input logic p, input int xv, input int yv, input int cv);
    pix.plot   = p;
    pix.x      = 8'(xv);
    pix.y      = 7'(yv);
    pix.colour = 3'(cv);
  endtask

  initial begin
    int exp_drop;
    reset = 1'b1;
    clear = 1'b0;
    clear_colour = 3'd0;
    set_plot(1'b0, 0, 0, 0);
    tick();
    tick();
    check("rst_ready", pix.ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_drop", dropped_count, 0);
    reset = 1'b0;
    tick();

    // single plot: accepted on one edge, written on the next
    set_plot(1'b1, 58, 100, 2);
    check("single_ready", pix.ready, 1);
    tick();
    set_plot(1'b0, 0, 0, 0);
    check("single_we_early", mem_we, 0);
    check("single_busy_q", busy, 1);
    tick();
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 16058);
    check("single_data", mem_data, 2);
    check("single_busy", busy, 0);
    tick();
    check("single_we_off", mem_we, 0);
    check("single_addr_hold", mem_addr, 16058);

    // six back-to-back plots on row 5
    for (int i = 0; i < 6; i++) begin
      set_plot(1'b1, 10 + i, 5, i);
      check("b2b_ready", pix.ready, 1);
      tick();
      if (i == 0) check("b2b_first_we", mem_we, 0);
      else begin
        check("b2b_we", mem_we, 1);
        check("b2b_addr", mem_addr, 810 + i - 1);
        check("b2b_data", mem_data, (i - 1) % 8);
      end
    end
    set_plot(1'b0, 0, 0, 0);
    tick();
    check("b2b_last_we", mem_we, 1);
    check("b2b_last_addr", mem_addr, 815);
    check("b2b_last_data", mem_data, 5);
    tick();
    check("b2b_done_we", mem_we, 0);
    check("b2b_done_busy", busy, 0);

    // out-of-range requests are consumed without writes
    set_plot(1'b1, 160, 0, 1);
    check("oor_ready", pix.ready, 1);
    tick();
    check("oor_we0", mem_we, 0);
    set_plot(1'b1, 0, 120, 1);
    tick();
    check("oor_we1", mem_we, 0);
    set_plot(1'b1, 255, 127, 1);
    tick();
    check("oor_we2", mem_we, 0);
    set_plot(1'b0, 0, 0, 0);
    tick();
    check("oor_we3", mem_we, 0);
    check("oor_busy", busy, 0);
`ifdef PLOT_DROP_COUNT_EN
    exp_drop = 3;
`else
    exp_drop = 0;
`endif
    check("drop_3", dropped_count, exp_drop);
    for (int i = 0; i < 300; i++) begin
      set_plot(1'b1, 200, 0, 0);
      tick();
      if (mem_we !== 1'b0) check("oor_bulk_we", mem_we, 0);
    end
    set_plot(1'b0, 0, 0, 0);
    tick();
`ifdef PLOT_DROP_COUNT_EN
    exp_drop = 255;
`else
    exp_drop = 0;
`endif
    check("drop_sat", dropped_count, exp_drop);

    // three plots, then a fourth alongside a clear pulse
    set_plot(1'b1, 1, 0, 1);
    tick();
    set_plot(1'b1, 2, 0, 2);
    tick();
    check("cq_w0_addr", mem_addr, 1);
    check("cq_w0_data", mem_data, 1);
    set_plot(1'b1, 3, 0, 3);
    tick();
    check("cq_w1_addr", mem_addr, 2);
    set_plot(1'b1, 4, 1, 4);
    clear = 1'b1;
    clear_colour = 3'd0;
    check("cq_ready_before", pix.ready, 1);
    tick();
    set_plot(1'b0, 0, 0, 0);
    clear = 1'b0;
    check("cq_w2_addr", mem_addr, 3);
    check("cq_w2_we", mem_we, 1);
    check("cq_ready_pend", pix.ready, 0);
    check("cq_busy_pend", busy, 1);
    tick();
    check("cq_w3_we", mem_we, 1);
    check("cq_w3_addr", mem_addr, 164);
    check("cq_w3_data", mem_data, 4);
    tick();
    check("cq_gap_we", mem_we, 0);
    check("cq_gap_ready", pix.ready, 0);
    for (int a = 0; a < 19200; a++) begin
      tick();
      clear = 1'b0;
      check("sweep_we", mem_we, 1);
      check("sweep_addr", mem_addr, a);
      check("sweep_data", mem_data, 0);
      if (a < 19199) check("sweep_ready", pix.ready, 0);
      if (a == 100) begin
        check("sweep_busy", busy, 1);
        clear = 1'b1;
        clear_colour = 3'd7;
      end
    end
    tick();
    check("sweep_end_we", mem_we, 0);
    check("sweep_end_busy", busy, 0);
    check("sweep_end_ready", pix.ready, 1);
    tick();
    check("sweep_norestart_we", mem_we, 0);
    check("sweep_norestart_busy", busy, 0);

    // reset in the middle of a sweep
    clear = 1'b1;
    clear_colour = 3'd5;
    tick();
    clear = 1'b0;
    tick();
    for (int a = 0; a <= 5000; a++) tick();
    check("mid_we", mem_we, 1);
    check("mid_addr", mem_addr, 5000);
    check("mid_data", mem_data, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_we", mem_we, 0);
    check("rst2_ready", pix.ready, 1);
    check("rst2_busy", busy, 0);
    check("rst2_addr", mem_addr, 0);
    check("rst2_drop", dropped_count, 0);
    set_plot(1'b1, 159, 119, 6);
    tick();
    set_plot(1'b0, 0, 0, 0);
    tick();
    check("post_we", mem_we, 1);
    check("post_addr", mem_addr, 19199);
    check("post_data", mem_data, 6);
    tick();
    check("post_we_off", mem_we, 0);
    check("post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_plot_sink.md
Name: pixel_plot_sink

Overview:
- Responder end of the pixel plot interface (x, y, colour, plot) that game datapaths drive.
- Accepts plot requests into a small FIFO and checks their bounds.
- Converts each accepted pixel to a linear framebuffer address (y*WIDTH + x) and issues single-cycle writes to a framebuffer RAM write port.
- Also performs a full-screen clear sweep on command; it sits between the game datapaths and the framebuffer memory.

Parameters:
- WIDTH, 160, visible columns; x range 0..WIDTH-1
- HEIGHT, 120, visible rows; y range 0..HEIGHT-1
- COLOUR_BITS, 3, colour width
- FIFO_DEPTH, 4, plot request buffer entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- plot  in  1  plot request; accepted on a cycle where plot && ready
- x  in  8  column of the request
- y  in  7  row of the request
- colour  in  COLOUR_BITS  pixel colour
- ready  out  1  high when a request can be accepted this cycle
- clear  in  1  single-cycle pulse requesting a full-screen fill
- clear_colour  in  COLOUR_BITS  fill colour, sampled on the clear pulse
- busy  out  1  high while the FIFO is non-empty or a clear is pending or active
- mem_addr  out  15  framebuffer write address
- mem_data  out  COLOUR_BITS  framebuffer write data
- mem_we  out  1  framebuffer write strobe, one cycle per pixel
- dropped_count  out  8  out-of-range request counter (see Optional Feature)

Behaviour:
- Reset values: ready=1, busy=0, mem_we=0, mem_addr=0, mem_data=0, dropped_count=0. Reset flushes the FIFO, aborts any clear mid-sweep, and discards a pending clear.
- Accept and bounds check:
  - A request is accepted when plot && ready.
  - If x>=WIDTH or y>=HEIGHT, the request is consumed (counts as accepted) but is not enqueued and produces no write.
  - In-range requests are enqueued as {addr, colour}, with addr = y*WIDTH + x computed at enqueue time in 15-bit arithmetic.
- ready = !fifo_full && !clear_pending && state!=CLEAR.
- Simultaneous enqueue and dequeue on a full FIFO is not allowed: ready is already 0 when the FIFO is full.
- States:
  - IDLE: if the FIFO is non-empty, pop the head, drive mem_addr/mem_data, and assert mem_we for one cycle (one write per cycle). If the FIFO is empty and clear_pending, go to CLEAR with the sweep counter at 0.
  - CLEAR: each cycle write mem_addr=counter, mem_data=latched clear_colour, mem_we=1, then increment the counter. After writing address WIDTH*HEIGHT-1 (19199), clear clear_pending and return to IDLE. The full sweep is 19200 consecutive write cycles.
- Latency: an in-range request accepted at cycle N, with the FIFO empty and no clear, produces mem_we=1 at cycle N+1. The FIFO drains at one entry per cycle in arrival order.
- Clear request:
  - clear sets clear_pending and latches clear_colour.
  - Entries already queued are written before the sweep starts; plot and clear in the same cycle means the plot is accepted first.
  - A clear pulse while clear_pending or in CLEAR is ignored; the first clear_colour is kept.
- busy = fifo non-empty || clear_pending || state==CLEAR.
- mem_addr and mem_data hold their last values when mem_we=0.

Optional Feature:
- Macro PLOT_DROP_COUNT_EN.
- When defined: dropped_count increments on each accepted out-of-range request, saturates at 255, and is cleared only by reset.
- When undefined: dropped_count is tied to 0, with no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then a single plot x=58, y=100, colour=3'b010 -> next cycle mem_we=1, mem_addr=16058, mem_data=3'b010; then busy=0.
- Plot held high for 6 back-to-back cycles at increasing x -> ready drops only if the FIFO fills. All 6 writes appear in order on consecutive cycles with no loss and no duplicates.
- Out-of-range requests (x=160,y=0), (x=0,y=120), (x=255,y=127) -> no mem_we; with PLOT_DROP_COUNT_EN, dropped_count=3. Then 300 further bad plots -> dropped_count=255.
- Queue 3 pixels, then pulse clear with clear_colour=3'b000 in the same cycle as the 4th plot:
  - the 4 pixels are written first;
  - then addresses 0..19199 are written with 3'b000;
  - ready=0 throughout the sweep;
  - busy falls the cycle after address 19199 is written.
- Second clear pulse with a different colour mid-sweep -> ignored; the sweep completes with the first colour and no restart.
- Assert reset mid-sweep at address 5000 -> next cycle mem_we=0, ready=1, busy=0; a plot after reset is written normally.
